// File: rtl/mdu_pkg.sv
// Shared op encodings, FSM state type and op-class helpers for the multiply/divide unit.
// MDU_MADD_EN: when defined, OP_MADD/OP_MADDU are mult-class ops.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8
    } mdu_op_e;

    typedef enum logic {IDLE, BUSY} state_e;

    function automatic logic is_mult(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit product or {remainder, quotient} for the issuing op.
// The result is don't-care on divide-by-zero; the top level discards it.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        div0,
    output logic [63:0] result
);

    logic signed [63:0] a_s, b_s, prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] q_s, r_s;
    logic        [31:0] q_u, r_u;

    always_comb begin
        a_s    = {{32{rs_val[31]}}, rs_val};
        b_s    = {{32{rt_val[31]}}, rt_val};
        prod_s = a_s * b_s;
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};
        q_s    = '0;
        r_s    = '0;
        q_u    = '0;
        r_u    = '0;
        // Guard the dividers so a zero divisor never reaches them; the
        // most-negative / -1 case is pinned rather than left to wrap.
        if (!div0) begin
            q_u = rs_val / rt_val;
            r_u = rs_val % rt_val;
            if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
                q_s = 32'sh8000_0000;
                r_s = '0;
            end else begin
                q_s = $signed(rs_val) / $signed(rt_val);
                r_s = $signed(rs_val) % $signed(rt_val);
            end
        end
        case (op)
            OP_MULT, OP_MADD:   result = prod_s;
            OP_MULTU, OP_MADDU: result = prod_u;
            OP_DIV:             result = {r_s, q_s};
            OP_DIVU:            result = {r_u, q_u};
            default:            result = '0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result is latched at issue and retired
// after a fixed busy period. MDU_MADD_EN adds multiply-accumulate into HI/LO at retirement.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_e        state;
    logic [CW-1:0] cnt;
    logic [63:0]   pending;
    logic          pend_keep;
    logic          div0;
    logic [63:0]   res;
    logic [63:0]   retire_val;

    assign div0 = (rt_val == 32'd0);

    mdu_arith u_arith (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .div0   (div0),
        .result (res)
    );

`ifdef MDU_MADD_EN
    logic pend_acc;
    // Accumulate against HI/LO as they stand at retirement, not at issue.
    assign retire_val = pend_acc ? ({hi, lo} + pending) : pending;
`else
    assign retire_val = pending;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            pending   <= '0;
            pend_keep <= 1'b0;
`ifdef MDU_MADD_EN
            pend_acc  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mult(op) || is_div(op)) begin
                            state     <= BUSY;
                            busy      <= 1'b1;
                            cnt       <= is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            pending   <= res;
                            pend_keep <= is_div(op) && div0;
`ifdef MDU_MADD_EN
                            pend_acc  <= (op == OP_MADD) || (op == OP_MADDU);
`endif
                        end else if (op == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (op == OP_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        if (!pend_keep)
                            {hi, lo} <= retire_val;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
